instruction_fetcher: RTL

//  Per-core fetch stage feeding the instruction decoder. On core_state==FETCH it

---
 rtl/instruction_fetcher.sv | 109 ++++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// Fetch stage: one valid/ready read per FETCH, a one-entry last-PC buffer,
// and a timeout that substitutes a RET instruction for a hung memory read.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32,
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;
  localparam int         CNT_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PROGRAM_MEM_DATA_BITS-1:0] RET_INSTR =
    {6'b111111, {(PROGRAM_MEM_DATA_BITS - 6){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t                             state_q;
  logic                               valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q;
  logic                               err_q;
  logic                               buf_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_pc_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [CNT_W-1:0]                   cnt_d;
  logic                               buf_hit;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    buf_hit = buf_valid_q && (current_pc == buf_pc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (buf_hit) begin
              instr_q <= buf_data_q;
              state_q <= S_FETCHED;
            end else begin
              valid_q <= 1'b1;
              addr_q  <= current_pc;
              cnt_q   <= '0;
              state_q <= S_FETCHING;
            end
          end
        end
        S_FETCHING: begin
          cnt_q <= cnt_d;
          // A response on the terminal-count edge still counts as a success.
          if (mem_read_ready) begin
            instr_q     <= mem_read_data;
            buf_pc_q    <= addr_q;
            buf_data_q  <= mem_read_data;
            buf_valid_q <= 1'b1;
            valid_q     <= 1'b0;
            state_q     <= S_FETCHED;
          end else if (cnt_q == CNT_LAST) begin
            instr_q     <= RET_INSTR;
            err_q       <= 1'b1;
            buf_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            state_q     <= S_FETCHED;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign fetch_error      = err_q;

endmodule
